// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RISC-V immediate decoder behind a valid/ready stage
// with a 2-entry skid buffer (output entry + skid entry) and synchronous flush.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_imm_type,
    output logic             o_illegal,
    output logic [31:0]      o_instr,
    output logic [TAG_W-1:0] o_tag
);
    localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6, T_SH = 3'd7;
    localparam logic [6:0] OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic             ill;
        logic [31:0]      instr;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t          dec, out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic            in_xfer, is_shift;
    logic [2:0]      typ;
    logic            ill;
    logic [XLEN-1:0] imm;

    assign o_ready = !skid_valid_q;
    assign in_xfer = i_valid && o_ready;
    // funct3 001 and 101 are the shift encodings
    assign is_shift = i_instr[13:12] == 2'b01;

    always_comb begin
        typ = T_NONE;
        ill = 1'b0;
        case (i_instr[6:0])
            7'b0110111, 7'b0010111: typ = T_U;
            7'b1101111:             typ = T_J;
            7'b1100111, 7'b0000011: typ = T_I;
            7'b0100011:             typ = T_S;
            7'b1100011:             typ = T_B;
            OP_IMM:                 typ = is_shift ? T_SH : T_I;
            OP_IMM32: begin
                typ = (XLEN == 64) ? (is_shift ? T_SH : T_I) : T_NONE;
                ill = XLEN != 64;
            end
            7'b1110011:             typ = i_instr[14] ? T_Z : T_NONE;
            7'b0110011, 7'b0001111: typ = T_NONE;
            7'b0111011:             ill = XLEN != 64;
            default:                ill = 1'b1;
        endcase
        case (typ)
            T_I:     imm = XLEN'($signed(i_instr[31:20]));
            T_S:     imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            T_B:     imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
            T_U:     imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            T_J:     imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
            T_Z:     imm = XLEN'(i_instr[19:15]);
            T_SH:    imm = (XLEN == 64 && i_instr[6:0] == OP_IMM) ? XLEN'(i_instr[25:20]) : XLEN'(i_instr[24:20]);
            default: imm = '0;
        endcase
        dec = '{imm: imm, typ: typ, ill: ill, instr: i_instr, tag: i_tag};
    end

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || i_ready) begin
            // skid is only ever full while the output is held, so it drains first
            out_valid_d  = skid_valid_q || in_xfer;
            out_d        = skid_valid_q ? skid_q : (in_xfer ? dec : out_q);
            skid_valid_d = 1'b0;
        end else if (in_xfer) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign o_valid    = out_valid_q;
    assign o_imm      = out_q.imm;
    assign o_imm_type = out_q.typ;
    assign o_illegal  = out_q.ill;
    assign o_instr    = out_q.instr;
    assign o_tag      = out_q.tag;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: drives one instruction stream into XLEN=32 and XLEN=64 instances
// and compares both against a 2-deep FIFO model with a format-rule immediate decoder.
module tb_imm_decode_stage;
    typedef struct { logic [31:0] ins; logic [31:0] tag; } txn_t;
    typedef struct { logic [63:0] imm; logic [2:0] typ; logic ill; } exp_t;
    typedef struct {
        logic [31:0] ins;
        logic [63:0] i32; logic [2:0] t32; logic l32;
        logic [63:0] i64; logic [2:0] t64; logic l64;
    } vec_t;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
    logic [31:0] i_instr = 32'd0, i_tag = 32'd0;
    logic        r32, v32, l32, r64, v64, l64;
    logic [31:0] m32, oi32, ot32, oi64, ot64;
    logic [63:0] m64;
    logic [2:0]  t32, t64;
    int          checks = 0, passes = 0;
    txn_t        q[$];
    logic [31:0] seen[$];
    vec_t        vecs[18];
    exp_t        e;

    always #5 i_clk = ~i_clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) d32 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(r32),
        .i_instr(i_instr), .i_tag(i_tag), .o_valid(v32), .i_ready(i_ready), .o_imm(m32),
        .o_imm_type(t32), .o_illegal(l32), .o_instr(oi32), .o_tag(ot32));

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) d64 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(r64),
        .i_instr(i_instr), .i_tag(i_tag), .o_valid(v64), .i_ready(i_ready), .o_imm(m64),
        .o_imm_type(t64), .o_illegal(l64), .o_instr(oi64), .o_tag(ot64));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] ins, input int xlen);
        exp_t        r;
        longint      s, v;
        logic [6:0]  op;
        logic [2:0]  f3;
        op = ins[6:0];
        f3 = ins[14:12];
        s  = longint'($signed(ins));
        r  = '{64'd0, 3'd0, 1'b0};
        case (op)
            7'h37, 7'h17: r.typ = 3'd4;
            7'h6F:        r.typ = 3'd5;
            7'h67, 7'h03: r.typ = 3'd1;
            7'h23:        r.typ = 3'd2;
            7'h63:        r.typ = 3'd3;
            7'h13:        r.typ = (f3 == 3'd1 || f3 == 3'd5) ? 3'd7 : 3'd1;
            7'h1B: if (xlen == 64) r.typ = (f3 == 3'd1 || f3 == 3'd5) ? 3'd7 : 3'd1;
                   else r.ill = 1'b1;
            7'h73:        r.typ = (f3 >= 3'd4) ? 3'd6 : 3'd0;
            7'h33, 7'h0F: r.typ = 3'd0;
            7'h3B:        r.ill = xlen != 64;
            default:      r.ill = 1'b1;
        endcase
        case (r.typ)
            3'd1: v = s >>> 20;
            3'd2: v = ((s >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd3: v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd4: v = longint'($signed(ins & 32'hFFFFF000));
            3'd5: v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd6: v = longint'((ins >> 15) & 32'h1F);
            3'd7: v = longint'((ins >> 20) & ((xlen == 64 && op == 7'h13) ? 32'h3F : 32'h1F));
            default: v = 0;
        endcase
        r.imm = (xlen == 32) ? (64'(v) & 64'hFFFFFFFF) : 64'(v);
        return r;
    endfunction

    task automatic cmp_dut(input string nm, input int xlen, input logic v, input logic r,
                           input logic [63:0] imm, input logic [2:0] t, input logic il,
                           input logic [31:0] ins, input logic [31:0] tg);
        exp_t x;
        chk({nm, "_valid"}, 64'(v), 64'(q.size() != 0));
        chk({nm, "_ready"}, 64'(r), 64'(q.size() < 2));
        if (q.size() != 0) begin
            x = model(q[0].ins, xlen);
            chk({nm, "_imm"}, imm, x.imm);
            chk({nm, "_type"}, 64'(t), 64'(x.typ));
            chk({nm, "_illegal"}, 64'(il), 64'(x.ill));
            chk({nm, "_instr"}, 64'(ins), 64'(q[0].ins));
            chk({nm, "_tag"}, 64'(tg), 64'(q[0].tag));
        end
    endtask

    always @(negedge i_clk) begin
        bit rdy;
        if (!i_rst_n) q.delete();
        else begin
            cmp_dut("x32", 32, v32, r32, 64'(m32), t32, l32, oi32, ot32);
            cmp_dut("x64", 64, v64, r64, m64, t64, l64, oi64, ot64);
            rdy = q.size() < 2;
            if (i_flush) q.delete();
            else begin
                if (q.size() != 0 && i_ready) begin
                    seen.push_back(ot32);
                    void'(q.pop_front());
                end
                if (i_valid && rdy) q.push_back('{i_instr, i_tag});
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [31:0] tag);
        bit ok = 1'b0;
        i_valid = 1'b1;
        i_instr = ins;
        i_tag   = tag;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge i_clk);
            ok = r32;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        chk("drive_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge i_clk);
        @(negedge i_clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        vecs = '{
            '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},
            '{32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0},
            '{32'hFE0008E3, 64'hFFFFFFF0, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF0, 3'd3, 1'b0},
            '{32'h800000B7, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0},
            '{32'h0040006F, 64'h00000004, 3'd5, 1'b0, 64'h0000000000000004, 3'd5, 1'b0},
            '{32'h03F0D093, 64'h0000001F, 3'd7, 1'b0, 64'h000000000000003F, 3'd7, 1'b0},
            '{32'h0011D073, 64'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0},
            '{32'h0000007F, 64'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1},
            '{32'h00000091, 64'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1},
            '{32'h0000001B, 64'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd1, 1'b0},
            '{32'h03F0109B, 64'h00000000, 3'd0, 1'b1, 64'h000000000000001F, 3'd7, 1'b0},
            '{32'h0000003B, 64'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0},
            '{32'h00000033, 64'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0},
            '{32'h00002073, 64'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0},
            '{32'hFFFFF017, 64'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0},
            '{32'h7FF02083, 64'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0},
            '{32'h800000E7, 64'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0},
            '{32'hFFFFF06F, 64'hFFFFFFFE, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFE, 3'd5, 1'b0}};

        for (int k = 0; k < 18; k++) begin
            e = model(vecs[k].ins, 32);
            chk($sformatf("model32_%0d_imm", k), e.imm, vecs[k].i32);
            chk($sformatf("model32_%0d_type", k), 64'(e.typ), 64'(vecs[k].t32));
            chk($sformatf("model32_%0d_ill", k), 64'(e.ill), 64'(vecs[k].l32));
            e = model(vecs[k].ins, 64);
            chk($sformatf("model64_%0d_imm", k), e.imm, vecs[k].i64);
            chk($sformatf("model64_%0d_type", k), 64'(e.typ), 64'(vecs[k].t64));
            chk($sformatf("model64_%0d_ill", k), 64'(e.ill), 64'(vecs[k].l64));
        end

        repeat (2) @(negedge i_clk);
        chk("rst_valid", 64'(v32), 64'd0);
        chk("rst_ready", 64'(r32), 64'd1);
        chk("rst_imm32", 64'(m32), 64'd0);
        chk("rst_imm64", m64, 64'd0);
        chk("rst_type", 64'(t32), 64'd0);
        chk("rst_illegal", 64'(l32), 64'd0);
        chk("rst_instr", 64'(oi32), 64'd0);
        chk("rst_tag", 64'(ot32), 64'd0);
        chk("rst_ready64", 64'(r64), 64'd1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        drive(vecs[0].ins, 32'd0);
        @(negedge i_clk);
        chk("lat_valid", 64'(v32), 64'd1);
        chk("lat_imm", 64'(m32), 64'hFFFFFFFF);
        chk("lat_type", 64'(t32), 64'd1);
        chk("lat_illegal", 64'(l32), 64'd0);
        @(posedge i_clk);
        #1;
        for (int k = 1; k < 18; k++) drive(vecs[k].ins, 32'(k));
        drain();

        i_ready = 1'b0;
        seen.delete();
        fork
            for (int k = 0; k < 4; k++) drive(vecs[k].ins, 32'(k));
            begin
                @(posedge i_clk);
                @(posedge i_clk);
                @(negedge i_clk);
                chk("bp_ready32", 64'(r32), 64'd0);
                chk("bp_ready64", 64'(r64), 64'd0);
                chk("bp_head_tag", 64'(ot32), 64'd0);
                @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", 64'(seen.size()), 64'd4);
        for (int k = 0; k < 4 && k < seen.size(); k++) chk($sformatf("bp_order_%0d", k), 64'(seen[k]), 64'(k));

        i_ready = 1'b0;
        drive(vecs[1].ins, 32'd10);
        drive(vecs[2].ins, 32'd11);
        chk("flush_full", 64'(r32), 64'd0);
        seen.delete();
        i_valid = 1'b1;
        i_instr = vecs[3].ins;
        i_tag   = 32'd99;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("flush_valid32", 64'(v32), 64'd0);
        chk("flush_ready32", 64'(r32), 64'd1);
        chk("flush_valid64", 64'(v64), 64'd0);
        chk("flush_ready64", 64'(r64), 64'd1);
        @(posedge i_clk);
        #1 i_ready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        chk("flush_dropped", 64'(seen.size()), 64'd0);

        drive(vecs[6].ins, 32'd12);
        drain();

        i_ready = 1'b0;
        drive(vecs[4].ins, 32'd20);
        chk("arst_pre", 64'(v32), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid32", 64'(v32), 64'd0);
        chk("arst_valid64", 64'(v64), 64'd0);
        chk("arst_ready", 64'(r32), 64'd1);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        i_ready = 1'b1;
        drive(vecs[5].ins, 32'd21);
        drive(vecs[10].ins, 32'd22);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Registered, parametrised successor to the combinational immediate generator.
- Decodes the opcode and emits exactly one sign-/zero-extended immediate of width XLEN plus a format code, an illegal flag and passthrough sideband.
- Sits between fetch and execute as a valid/ready pipeline stage with a 2-entry skid buffer and flush.
- Supports RV32 and RV64 shift-amount rules and CSR zimm, which the single-cycle generator lacks.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (typically PC) carried alongside the instruction.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush; discards all held entries.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; equals NOT skid_full.
- i_instr  in  32  instruction word.
- i_tag  in  TAG_W  sideband, passed through unchanged.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_imm  out  XLEN  selected immediate.
- o_imm_type  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shamt).
- o_illegal  out  1  opcode not recognised, or instr[1:0] != 2'b11.
- o_instr  out  32  registered copy of the instruction.
- o_tag  out  TAG_W  registered copy of the tag.

Behaviour:
- Reset, asynchronous: o_valid=0, o_imm=0, o_imm_type=0, o_illegal=0, o_instr=0, o_tag=0, skid entry empty. o_ready=1 while held in reset and afterwards.
- Decode is combinational on the input side and registered into the output entry. All sign extension is from instr[31] to XLEN.
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}, sign-extended on XLEN=64.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Opcode map:
  - LUI/AUIPC (0110111/0010111) → U.
  - JAL (1101111) → J.
  - JALR (1100111), LOAD (0000011) → I.
  - STORE (0100011) → S.
  - BRANCH (1100011) → B.
  - OP-IMM (0010011): funct3 001/101 → SH; all other funct3 → I.
  - OP-IMM-32 (0011011): funct3 001/101 → SH with 5-bit shamt; other funct3 → I. Legal only when XLEN=64; illegal on XLEN=32.
  - SYSTEM (1110011): funct3[2]=1 → Z; else NONE.
  - OP (0110011), OP-32 (0111011, XLEN=64 only), FENCE (0001111) → NONE, not illegal.
  - Anything else → NONE with illegal=1.
- SH: zero-extended shamt. Width is instr[24:20] for XLEN=32 and for OP-IMM-32; instr[25:20] for OP-IMM on XLEN=64.
- Z: zero-extended instr[19:15].
- NONE (including illegal): o_imm=0.
- Handshake:
  - Input transfer when i_valid & o_ready.
  - Output transfer when o_valid & i_ready.
  - Output registers and sideband hold stable while o_valid & !i_ready.
- Latency: 1 cycle from input transfer to o_valid when the output is empty or draining. Full throughput: 1 instruction/cycle with i_ready held high.
- Skid buffer:
  - If the output entry is held (o_valid & !i_ready) and an input transfers, the decoded result goes to the skid entry; o_ready drops next cycle.
  - When the output drains, the skid entry moves to the output, or a new input if the skid is empty.
  - Order is strictly preserved. No entry is lost or duplicated.
- Simultaneous output drain and input while the skid is full: impossible, because o_ready=0.
- Simultaneous drain and input with the skid empty: the new entry loads the output.
- Flush has priority over every transfer in the same cycle. Next cycle: o_valid=0, skid empty, o_ready=1. An input offered in the flush cycle is dropped. Data registers may keep stale values.
- Reset mid-stream clears both entries immediately, without waiting for a clock edge.

Test Plan:
- Reset release, then i_instr=0xFFF00093 (addi x1,x0,-1), i_ready=1 → next cycle o_valid=1, o_imm=0xFFFFFFFF, type=1, illegal=0.
- Formats on XLEN=32:
  - 0xFE112E23 (sw) → S, imm 0xFFFFFFFC.
  - 0xFE0008E3 (beq -16) → B, imm 0xFFFFFFF0.
  - 0x800000B7 (lui) → U, imm 0x80000000.
  - 0x0040006F (jal +4) → J, imm 0x00000004.
- XLEN=64 shifts and CSR:
  - 0x03F0D093 (srli shamt 63) → SH, imm 63.
  - lui 0x800000B7 → imm 0xFFFFFFFF80000000.
  - 0x0011D073 (csrrwi x0,1,3) → Z, imm 3.
- Backpressure: stream 4 instructions with tags 0..3 at i_valid=1, holding i_ready=0 for 3 cycles → o_ready=0 after 2 accepted. Release i_ready → outputs emerge with tags 0,1,2,3 in order; none lost or duplicated.
- Flush with both entries full and i_valid=1 → next cycle o_valid=0, o_ready=1; the offered instruction never appears at the output.
- Illegal encodings:
  - 0x0000007F → NONE, imm 0, illegal=1.
  - instr[1:0]=01 → illegal=1.
  - 0x0000001B on XLEN=32 → illegal=1.
  - Asserting i_rst_n low mid-stream → o_valid drops asynchronously.
